// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single picorv32-style memory bus.
// Optional watchdog completion is enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        bus_error
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t     state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic [1:0] grant_nxt;
  logic       sel_valid;
  logic       timeout;
  logic       done;

  assign sel_valid = (state == GNT0) ? m0_mem_valid :
                     (state == GNT1) ? m1_mem_valid : 1'b0;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Counter sits at zero in IDLE, so every grant starts counting from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = (state != IDLE) && !mem_ready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [CNT_W+31:0] unused_params;
  assign unused_params = {CNT_W'(TIMEOUT_CYCLES), ERR_RDATA};
  assign timeout = 1'b0;
`endif

  assign done = mem_ready | timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 2'b00;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant      <= grant_nxt;
    end
  end

  // Next state: a dropped request aborts without touching fairness history.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (m0_mem_valid && m1_mem_valid) begin
          state_nxt = last_grant ? GNT0 : GNT1;
        end else if (m0_mem_valid) begin
          state_nxt = GNT0;
        end else if (m1_mem_valid) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_mem_valid) begin
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_mem_valid) begin
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    grant_nxt = {state_nxt == GNT1, state_nxt == GNT0};
  end

  // Bus and response muxes follow the registered state.
  always_comb begin
    mem_valid    = 1'b0;
    mem_instr    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    m0_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_ready = 1'b0;
    m1_mem_rdata = '0;
    bus_error    = sel_valid & timeout & !mem_ready;
    unique case (state)
      GNT0: begin
        mem_valid    = m0_mem_valid;
        mem_instr    = m0_mem_instr;
        mem_addr     = m0_mem_addr;
        mem_wdata    = m0_mem_wdata;
        mem_wstrb    = m0_mem_wstrb;
        m0_mem_ready = m0_mem_valid & done;
        m0_mem_rdata = timeout ? ERR_RDATA : mem_rdata;
      end
      GNT1: begin
        mem_valid    = m1_mem_valid;
        mem_instr    = m1_mem_instr;
        mem_addr     = m1_mem_addr;
        mem_wdata    = m1_mem_wdata;
        mem_wstrb    = m1_mem_wstrb;
        m1_mem_ready = m1_mem_valid & done;
        m1_mem_rdata = timeout ? ERR_RDATA : mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the timeout section follows
// MEM_ARBITER_TIMEOUT_EN and runs the DUT with TIMEOUT_CYCLES = 4.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [3:0]  m0_mem_wstrb;
  logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0]  m1_mem_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant;
  logic        bus_error;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr),
    .m0_mem_addr(m0_mem_addr), .m0_mem_wdata(m0_mem_wdata),
    .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr),
    .m1_mem_addr(m1_mem_addr), .m1_mem_wdata(m1_mem_wdata),
    .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .grant(grant), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    reset = 1'b1;
    m0_mem_valid = 0; m0_mem_instr = 0; m0_mem_addr = 0; m0_mem_wdata = 0; m0_mem_wstrb = 0;
    m1_mem_valid = 0; m1_mem_instr = 0; m1_mem_addr = 0; m1_mem_wdata = 0; m1_mem_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_m0_ready", m0_mem_ready, 0);
    check("rst_m1_ready", m1_mem_ready, 0);
    check("rst_bus_error", bus_error, 0);

    // Single read from m0
    m0_mem_valid = 1; m0_mem_addr = 32'h0000_0100; m0_mem_wstrb = 0;
    #1;
    check("rd_idle_mem_valid", mem_valid, 0);
    tick();
    check("rd_grant", grant, 2'b01);
    check("rd_mem_valid", mem_valid, 1);
    check("rd_mem_addr", mem_addr, 32'h0000_0100);
    check("rd_mem_wstrb", mem_wstrb, 0);
    check("rd_m0_ready_early", m0_mem_ready, 0);
    tick();
    check("rd_m0_ready_wait", m0_mem_ready, 0);
    tick();
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    #1;
    check("rd_m0_ready", m0_mem_ready, 1);
    check("rd_m0_rdata", m0_mem_rdata, 32'h1234_5678);
    check("rd_m1_ready", m1_mem_ready, 0);
    check("rd_m1_rdata", m1_mem_rdata, 0);
    tick();
    m0_mem_valid = 0; mem_ready = 0; mem_rdata = 0;
    #1;
    check("rd_done_grant", grant, 2'b00);
    check("rd_done_mem_valid", mem_valid, 0);
    check("rd_done_m0_ready", m0_mem_ready, 0);

    // mem_ready while idle is ignored
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("idle_rdy_m0_ready", m0_mem_ready, 0);
    check("idle_rdy_m0_rdata", m0_mem_rdata, 0);
    tick();
    check("idle_rdy_grant", grant, 2'b00);
    mem_ready = 0; mem_rdata = 0;

    // Both masters requesting continuously: expect alternation starting at m0
    do_reset();
    m0_mem_valid = 1; m0_mem_addr = 32'h0000_0200;
    m1_mem_valid = 1; m1_mem_addr = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check("rr_grant", grant, exp_g);
      check("rr_mem_addr", mem_addr, (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0300);
      check("rr_m0_ready_wait", m0_mem_ready, 0);
      check("rr_m1_ready_wait", m1_mem_ready, 0);
      tick();
      mem_ready = 1; mem_rdata = 32'(k + 1);
      #1;
      check("rr_m0_ready", m0_mem_ready, (k % 2 == 0) ? 1 : 0);
      check("rr_m1_ready", m1_mem_ready, (k % 2 == 0) ? 0 : 1);
      tick();
      mem_ready = 0; mem_rdata = 0;
      #1;
      check("rr_idle_gap", grant, 2'b00);
    end
    m0_mem_valid = 0; m1_mem_valid = 0;

    // m1 write forwarding; m0 fields are non-zero but must not leak
    m0_mem_instr = 1; m0_mem_addr = 32'h1111_1111; m0_mem_wdata = 32'h2222_2222; m0_mem_wstrb = 4'hF;
    m1_mem_valid = 1; m1_mem_instr = 0; m1_mem_addr = 32'hFFFF_0060;
    m1_mem_wdata = 32'hA5A5_A5A5; m1_mem_wstrb = 4'b0011;
    mem_rdata = 32'h5555_AAAA;
    tick();
    check("wr_grant", grant, 2'b10);
    check("wr_mem_valid", mem_valid, 1);
    check("wr_mem_instr", mem_instr, 0);
    check("wr_mem_addr", mem_addr, 32'hFFFF_0060);
    check("wr_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("wr_mem_wstrb", mem_wstrb, 4'b0011);
    check("wr_m1_rdata", m1_mem_rdata, 32'h5555_AAAA);
    check("wr_m0_rdata", m0_mem_rdata, 0);
    mem_ready = 1;
    #1;
    check("wr_m1_ready", m1_mem_ready, 1);
    check("wr_m0_ready", m0_mem_ready, 0);
    tick();
    m1_mem_valid = 0; mem_ready = 0; mem_rdata = 0;

    // m0 abandons its request: abort, last grant (m1) unchanged -> m0 wins tie
    m0_mem_valid = 1; m0_mem_instr = 0; m0_mem_addr = 32'h0000_0400;
    tick();
    check("pv_grant", grant, 2'b01);
    m0_mem_valid = 0;
    #1;
    check("pv_m0_ready", m0_mem_ready, 0);
    tick();
    check("pv_abort_grant", grant, 2'b00);
    m0_mem_valid = 1; m1_mem_valid = 1;
    tick();
    check("pv_tie_grant", grant, 2'b01);
    mem_ready = 1;
    tick();
    mem_ready = 0; m0_mem_valid = 0; m1_mem_valid = 0;

    // Reset in the middle of a grant; last grant was m0 but reset restores m0 priority
    m0_mem_valid = 1;
    tick();
    check("mr_grant", grant, 2'b01);
    reset = 1;
    tick();
    check("mr_grant_after", grant, 2'b00);
    check("mr_mem_valid", mem_valid, 0);
    check("mr_m0_ready", m0_mem_ready, 0);
    check("mr_m1_ready", m1_mem_ready, 0);
    reset = 0; m1_mem_valid = 1;
    tick();
    check("mr_first_grant", grant, 2'b01);
    mem_ready = 1;
    tick();
    mem_ready = 0; m0_mem_valid = 0; m1_mem_valid = 0;

`ifdef MEM_ARBITER_TIMEOUT_EN
    do_reset();
    m0_mem_valid = 1; m1_mem_valid = 1;
    tick();
    check("to_grant", grant, 2'b01);
    for (int i = 1; i <= 3; i++) begin
      #1;
      check("to_m0_ready_wait", m0_mem_ready, 0);
      check("to_bus_error_wait", bus_error, 0);
      tick();
    end
    #1;
    check("to_m0_ready", m0_mem_ready, 1);
    check("to_m0_rdata", m0_mem_rdata, 32'hDEADBEEF);
    check("to_bus_error", bus_error, 1);
    check("to_m1_ready", m1_mem_ready, 0);
    tick();
    m0_mem_valid = 0;
    #1;
    check("to_idle_grant", grant, 2'b00);
    check("to_idle_bus_error", bus_error, 0);
    tick();
    check("to_m1_grant", grant, 2'b10);
    for (int i = 1; i <= 3; i++) begin
      tick();
    end
    mem_ready = 1; mem_rdata = 32'h0000_0077;
    #1;
    check("to_late_m1_ready", m1_mem_ready, 1);
    check("to_late_m1_rdata", m1_mem_rdata, 32'h0000_0077);
    check("to_late_bus_error", bus_error, 0);
    tick();
    m1_mem_valid = 0; mem_ready = 0; mem_rdata = 0;
`else
    do_reset();
    m0_mem_valid = 1; m1_mem_valid = 1;
    tick();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (grant !== 2'b01 || bus_error !== 1'b0 || m0_mem_ready !== 1'b0 || m1_mem_ready !== 1'b0)
        bad++;
      tick();
    end
    check("stall_bad_cycles", 32'(bad), 0);
    check("stall_grant", grant, 2'b01);
    do_reset();
    m0_mem_valid = 0; m1_mem_valid = 0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
